// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix bytes, frame states and device-response codes.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // Device replies and BAT codes that carry no key information.
  function automatic logic is_dev_response(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin sync, clock filter, start/data/parity/stop FSM and inter-edge timeout.
// byte_valid / frame_err are combinational in the fall-event cycle; no backpressure.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic             filt_clk, filt_prev, fall;
  logic [CNT_W-1:0] filt_cnt;
  logic [TO_W-1:0]  to_cnt;

  frame_state_t state, state_n;
  logic [2:0]   bit_cnt, bit_cnt_n;
  logic [7:0]   shreg, shreg_n;
  logic         par, par_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_dat;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      // Level follows the pin only after FILTER_LEN consecutive differing samples.
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall    = filt_prev & ~filt_clk;
  assign rx_byte = shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      if (fall || state_n == ST_IDLE) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!dat_s2) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = dat_s2;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (dat_s2 && (^{shreg, par})) byte_valid = 1'b1;
          else                           frame_err  = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT)) begin
      state_n   = ST_IDLE;
      frame_err = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes and the E1 Pause sequence into 17-bit scancode events.
// Outputs registered one cycle after the stop-bit fall event; no backpressure.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [16:0] scancode,
  output logic        scancode_ready,
  output logic        rx_error
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  logic       ext, brk;
  logic [2:0] skip;

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      scancode       <= '0;
      scancode_ready <= 1'b0;
      rx_error       <= 1'b0;
      ext            <= 1'b0;
      brk            <= 1'b0;
      skip           <= '0;
    end else begin
      scancode_ready <= 1'b0;
      rx_error       <= frame_err;
      if (frame_err) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (byte_valid) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (rx_byte == PS2_PAUSE) begin
          skip <= PAUSE_SKIP;
        end else if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else if (is_dev_response(rx_byte) && !ext && !brk) begin
          skip <= '0;
        end else if (ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) begin
          // Fake shift emitted around extended keys carries no key state.
          ext <= 1'b0;
          brk <= 1'b0;
        end else begin
          scancode       <= {brk, 7'b0, ext, rx_byte};
          scancode_ready <= 1'b1;
          ext            <= 1'b0;
          brk            <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: byte-level prefix model feeding an expected-event queue.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 28000;
  localparam int HALF       = 15;
  localparam int GAP        = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [16:0] scancode;
  logic        scancode_ready;
  logic        rx_error;

  ps2_scancode_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_dat       (ps2_dat),
    .scancode      (scancode),
    .scancode_ready(scancode_ready),
    .rx_error      (rx_error)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          ev_cnt = 0;
  int          err_cnt = 0;
  logic [16:0] last_sc = '0;
  logic [16:0] held = '0;
  logic [17:0] exp_q[$];
  logic        m_ext = 1'b0, m_brk = 1'b0;
  int          m_skip = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: what each received byte must produce.
  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
    end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      exp_q.push_back({1'b0, m_brk, 7'b0, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    exp_q.push_back({1'b1, 17'h0});
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    logic p;
    p = ~(^b) ^ flip_par;
    if (!flip_par && stop) model_byte(b);
    else                   model_err();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(stop);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_frame(bs[i], 1'b0, 1'b1);
  endtask

  task automatic expect_delta(input string name, input int ev0, input int er0,
                              input int dev, input int der, input logic [16:0] last);
    check({name, "_events"}, ev_cnt - ev0, dev);
    check({name, "_errors"}, err_cnt - er0, der);
    if (dev > 0) check({name, "_code"}, last_sc, last);
  endtask

  // Compare process: every output cycle is checked against the expected-event queue.
  always @(posedge clk) begin
    logic [17:0] e;
    #1;
    if (reset) begin
      check("reset_scancode", scancode, 0);
      check("reset_ready", scancode_ready, 0);
      check("reset_error", rx_error, 0);
      held = '0;
    end else begin
      if (scancode_ready && rx_error) check("ready_and_error", 1, 0);
      if (rx_error) begin
        err_cnt++;
        if (exp_q.size() == 0) check("unexpected_error", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("event_is_error", e[17], 1);
        end
      end
      if (scancode_ready) begin
        ev_cnt++;
        last_sc = scancode;
        held    = scancode;
        if (exp_q.size() == 0) check("unexpected_ready", scancode, 0);
        else begin
          e = exp_q.pop_front();
          check("event_is_code", e[17], 0);
          check("scancode", scancode, e[16:0]);
        end
      end else begin
        check("scancode_hold", scancode, held);
      end
    end
  end

  initial begin
    int ev0, er0;
    repeat (5) @(negedge clk);
    check("init_scancode", scancode, 0);
    check("init_ready", scancode_ready, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'h1C});
    expect_delta("make_1c", ev0, er0, 1, 0, 17'h0001C);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hF0, 8'h1C});
    expect_delta("break_1c", ev0, er0, 1, 0, 17'h1001C);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hE0, 8'hF0, 8'h75});
    expect_delta("ext_break_75", ev0, er0, 1, 0, 17'h10175);

    ev0 = ev_cnt; er0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_delta("bad_parity", ev0, er0, 0, 1, 17'h0);

    ev0 = ev_cnt; er0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bytes('{8'h6B});
    expect_delta("bad_stop_6b", ev0, er0, 1, 1, 17'h0006B);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    check("pause_silent", ev_cnt - ev0, 0);
    send_bytes('{8'h29});
    expect_delta("pause_then_29", ev0, er0, 1, 0, 17'h00029);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hFA});
    expect_delta("ack_dropped", ev0, er0, 0, 0, 17'h0);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h59, 8'h12});
    expect_delta("fake_shift", ev0, er0, 1, 0, 17'h00012);

    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hF0, 8'hAA});
    expect_delta("prefixed_aa", ev0, er0, 1, 0, 17'h100AA);

    // Sub-threshold low glitch with data low: must not be taken as a start bit.
    ev0 = ev_cnt; er0 = err_cnt;
    @(negedge clk);
    ps2_dat = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2_dat = 1'b1;
    repeat (GAP) @(negedge clk);
    send_bytes('{8'h1C});
    expect_delta("glitch", ev0, er0, 1, 0, 17'h0001C);

    // Pending E0, then a frame stalls after its 4th data bit.
    ev0 = ev_cnt; er0 = err_cnt;
    send_bytes('{8'hE0});
    model_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h29 >> i) & 8'h1) != 0);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (TIMEOUT + 1) @(negedge clk);
    repeat (GAP) @(negedge clk);
    check("timeout_error", err_cnt - er0, 1);
    send_bytes('{8'h29});
    expect_delta("after_timeout", ev0, er0, 1, 1, 17'h00029);

    // Reset in the middle of a 0x5A frame.
    ev0 = ev_cnt; er0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    ps2_dat = 1'b1;
    repeat (GAP) @(negedge clk);
    check("post_reset_scancode", scancode, 0);
    send_bytes('{8'h5A});
    expect_delta("reset_mid_frame", ev0, er0, 1, 0, 17'h0005A);

    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
